// File: rtl/hw_return_stack_pkg.sv
// hw_return_stack_pkg
//   Shared definitions for the hardware return/operand stack:
//   - default entry width and depth
//   - stack_op_e, the operation decoded from the push/pop strobes
//   - decode_op(), the helper that maps the push/pop pair onto stack_op_e
package hw_return_stack_pkg;

    localparam int DEF_DATA_W = 13;  // matches the instruction-memory address width
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        REPL = 2'd3   // push and pop together: replace the top entry
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = REPL;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hw_return_stack_if.sv
// hw_return_stack_if
//   Bundles the stack command and status signals.
//   master: control unit side (drives push/pop/load_sp/clr_err, reads status)
//   slave : the stack itself
//   Handshake: there is no backpressure. Each command strobe is sampled on
//   the rising clock edge and always takes effect in that cycle; the status
//   outputs reflect registered state only.
interface hw_return_stack_if
    import hw_return_stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              load_sp;
    logic [PTR_W:0]    sp_load_val;
    logic              clr_err;
    logic [DATA_W-1:0] pop_data;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_data, load_sp, sp_load_val, clr_err,
        input  pop_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, load_sp, sp_load_val, clr_err,
        output pop_data, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/hw_return_stack_regfile.sv
// hw_return_stack_regfile
//   DEPTH x DATA_W storage with one synchronous write port and one
//   combinational read port. Contents are not reset. Kept separate so it can
//   be swapped for a RAM macro later.
//   Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module hw_return_stack_regfile #(
    parameter int DATA_W = 13,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hw_return_stack.sv
// hw_return_stack
//   Dedicated stack for CALL/RET return addresses and PUSH/POP operands.
//   Ports:
//     clk, reset : clock (rising edge) and synchronous active-high reset
//     bus        : hw_return_stack_if.slave (commands in, top/status out)
//   Priority each cycle: reset > load_sp > push/pop.
//   CIRCULAR=0 rejects a push when full; CIRCULAR=1 overwrites the oldest entry.
module hw_return_stack
    import hw_return_stack_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit CIRCULAR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    hw_return_stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, top_ptr;
    logic [PTR_W:0]    cnt, cnt_nxt;
    logic              ovf, unf;
    logic              ovf_set, unf_set;
    logic              is_empty, is_full;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] rd_data;
    stack_op_e         op;

    assign top_ptr  = wr_ptr - PTR_ONE;   // wraps naturally modulo DEPTH
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_C);
    assign op       = decode_op(bus.push, bus.pop);

    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = wr_ptr;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = cnt;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (op)
            PUSH: begin
                if (!is_full) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_ONE;
                    cnt_nxt    = cnt + CNT_ONE;
                end else begin
                    // Full: circular mode overwrites the oldest slot, which is
                    // exactly the slot wr_ptr points at; count stays DEPTH.
                    ovf_set = 1'b1;
                    if (CIRCULAR) begin
                        wr_en      = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_ONE;
                    end
                end
            end
            POP: begin
                if (!is_empty) begin
                    wr_ptr_nxt = wr_ptr - PTR_ONE;
                    cnt_nxt    = cnt - CNT_ONE;
                end else begin
                    unf_set = 1'b1;
                end
            end
            REPL: begin
                if (!is_empty) begin
                    // Replace top: no pointer movement and no flag, even when full.
                    wr_en   = 1'b1;
                    wr_addr = top_ptr;
                end else begin
                    // Nothing to pop: behaves as a plain push, but flags the pop.
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_ONE;
                    cnt_nxt    = cnt + CNT_ONE;
                    unf_set    = 1'b1;
                end
            end
            default: ;
        endcase

        if (bus.load_sp) begin
            wr_en      = 1'b0;
            wr_ptr_nxt = bus.sp_load_val[PTR_W-1:0];
            cnt_nxt    = (bus.sp_load_val > DEPTH_C) ? DEPTH_C : bus.sp_load_val;
            ovf_set    = 1'b0;
            unf_set    = 1'b0;
        end

        if (reset) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            cnt    <= cnt_nxt;
            if (!bus.load_sp) begin
                // A new error in the same cycle as clr_err wins.
                ovf <= (ovf & ~bus.clr_err) | ovf_set;
                unf <= (unf & ~bus.clr_err) | unf_set;
            end
        end
    end

    hw_return_stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.push_data),
        .raddr (top_ptr),
        .rdata (rd_data)
    );

    assign bus.pop_data  = is_empty ? '0 : rd_data;
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;

endmodule

// File: tb/tb_hw_return_stack.sv
// tb_hw_return_stack
//   Two DEPTH=4 instances (CIRCULAR=0 and CIRCULAR=1) driven with identical
//   stimulus. Each is checked every cycle against its own stack model; the
//   directed table and hand sequences add fixed expected values.
module tb_hw_return_stack;
    import hw_return_stack_pkg::*;

    localparam int DW = 13;
    localparam int DP = 4;
    localparam int PW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- driver signals ----------------
    logic          d_push, d_pop, d_load, d_clr;
    logic [DW-1:0] d_data;
    logic [PW:0]   d_val;

    hw_return_stack_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
    hw_return_stack_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

    assign if0.push = d_push;  assign if1.push = d_push;
    assign if0.pop  = d_pop;   assign if1.pop  = d_pop;
    assign if0.push_data   = d_data; assign if1.push_data   = d_data;
    assign if0.load_sp     = d_load; assign if1.load_sp     = d_load;
    assign if0.sp_load_val = d_val;  assign if1.sp_load_val = d_val;
    assign if0.clr_err     = d_clr;  assign if1.clr_err     = d_clr;

    hw_return_stack #(.DATA_W(DW), .DEPTH(DP), .CIRCULAR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    hw_return_stack #(.DATA_W(DW), .DEPTH(DP), .CIRCULAR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Slots are absolute positions 0..DP-1; the top sits just below "next".
    int m_mem   [2][DP];
    bit m_known [2][DP];
    int m_next  [2];
    int m_cnt   [2];
    bit m_ovf   [2];
    bit m_unf   [2];

    function automatic void model_step(input int k, input bit circ);
        bit no, nu;
        no = 1'b0;
        nu = 1'b0;
        if (reset) begin
            m_next[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            return;
        end
        if (d_load) begin
            m_cnt[k]  = (int'(d_val) > DP) ? DP : int'(d_val);
            m_next[k] = int'(d_val) % DP;
            return;
        end
        if (d_push && d_pop && m_cnt[k] > 0) begin
            m_mem[k][(m_next[k] + DP - 1) % DP]   = int'(d_data);
            m_known[k][(m_next[k] + DP - 1) % DP] = 1'b1;
        end else if (d_push) begin
            if (d_pop) nu = 1'b1;   // pop half had nothing to remove
            if (m_cnt[k] < DP || circ) begin
                m_mem[k][m_next[k]]   = int'(d_data);
                m_known[k][m_next[k]] = 1'b1;
                m_next[k] = (m_next[k] + 1) % DP;
                if (m_cnt[k] < DP) m_cnt[k]++;
                else no = 1'b1;
            end else begin
                no = 1'b1;
            end
        end else if (d_pop) begin
            if (m_cnt[k] > 0) begin
                m_next[k] = (m_next[k] + DP - 1) % DP;
                m_cnt[k]--;
            end else begin
                nu = 1'b1;
            end
        end
        if (d_clr) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
        m_ovf[k] = m_ovf[k] | no;
        m_unf[k] = m_unf[k] | nu;
    endfunction

    task automatic model_check(input int k);
        int c, t, e, f, o, u, idx;
        if (k == 0) begin
            c = int'(if0.count); t = int'(if0.pop_data); e = int'(if0.empty);
            f = int'(if0.full);  o = int'(if0.overflow); u = int'(if0.underflow);
        end else begin
            c = int'(if1.count); t = int'(if1.pop_data); e = int'(if1.empty);
            f = int'(if1.full);  o = int'(if1.overflow); u = int'(if1.underflow);
        end
        chk($sformatf("m%0d_count", k), c, m_cnt[k]);
        chk($sformatf("m%0d_empty", k), e, int'(m_cnt[k] == 0));
        chk($sformatf("m%0d_full", k),  f, int'(m_cnt[k] == DP));
        chk($sformatf("m%0d_ovf", k),   o, int'(m_ovf[k]));
        chk($sformatf("m%0d_unf", k),   u, int'(m_unf[k]));
        idx = (m_next[k] + DP - 1) % DP;
        if (m_cnt[k] == 0) chk($sformatf("m%0d_top", k), t, 0);
        else if (m_known[k][idx]) chk($sformatf("m%0d_top", k), t, m_mem[k][idx]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic p, input logic po, input int data,
                         input logic l, input int val, input logic c);
        d_push = p; d_pop = po; d_data = DW'(data);
        d_load = l; d_val = (PW + 1)'(val); d_clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        model_check(0);
        model_check(1);
    endtask

    // ---------------- directed table (expected values for CIRCULAR=0) ----------------
    typedef struct {
        logic p, po; int data; logic l; int val; logic c;
        int e_cnt; int e_top; bit e_ovf; bit e_unf;
    } vec_t;
    vec_t vt[$];

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        chk("rst_count", int'(if0.count), 0);
        chk("rst_empty", int'(if0.empty), 1);
        chk("rst_full",  int'(if0.full), 0);
        chk("rst_ovf",   int'(if0.overflow), 0);
        chk("rst_unf",   int'(if0.underflow), 0);
        chk("rst_top",   int'(if0.pop_data), 0);

        //          p  po data   l val c   cnt top    ovf unf
        vt.push_back('{1, 0, 'h100, 0, 0, 0,  1, 'h100, 0, 0});
        vt.push_back('{1, 0, 'h200, 0, 0, 0,  2, 'h200, 0, 0});
        vt.push_back('{1, 0, 'h300, 0, 0, 0,  3, 'h300, 0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  2, 'h200, 0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  1, 'h100, 0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  0, 0,     0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  0, 0,     0, 1});
        vt.push_back('{0, 0, 0,     0, 0, 1,  0, 0,     0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 1,  0, 0,     0, 1});
        vt.push_back('{0, 0, 0,     0, 0, 1,  0, 0,     0, 0});
        vt.push_back('{1, 0, 1,     0, 0, 0,  1, 1,     0, 0});
        vt.push_back('{1, 0, 2,     0, 0, 0,  2, 2,     0, 0});
        vt.push_back('{1, 0, 3,     0, 0, 0,  3, 3,     0, 0});
        vt.push_back('{1, 0, 4,     0, 0, 0,  4, 4,     0, 0});
        vt.push_back('{1, 0, 5,     0, 0, 0,  4, 4,     1, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  3, 3,     1, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  2, 2,     1, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  1, 1,     1, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  0, 0,     1, 0});
        vt.push_back('{0, 0, 0,     0, 0, 1,  0, 0,     0, 0});
        vt.push_back('{1, 0, 'h0AA, 0, 0, 0,  1, 'h0AA, 0, 0});
        vt.push_back('{1, 1, 'h0BB, 0, 0, 0,  1, 'h0BB, 0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  0, 0,     0, 0});
        vt.push_back('{1, 1, 'h011, 0, 0, 0,  1, 'h011, 0, 1});
        vt.push_back('{0, 0, 0,     0, 0, 1,  1, 'h011, 0, 0});
        vt.push_back('{0, 1, 0,     0, 0, 0,  0, 0,     0, 0});
        vt.push_back('{1, 0, 'h021, 0, 0, 0,  1, 'h021, 0, 0});
        vt.push_back('{1, 0, 'h022, 0, 0, 0,  2, 'h022, 0, 0});
        vt.push_back('{1, 0, 'h023, 0, 0, 0,  3, 'h023, 0, 0});
        vt.push_back('{1, 0, 'h055, 1, 1, 0,  1, 'h021, 0, 0});
        vt.push_back('{0, 1, 0,     1, 3, 0,  3, 'h023, 0, 0});
        vt.push_back('{0, 0, 0,     1, 6, 0,  4, 'h022, 0, 0});

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].p, vt[i].po, vt[i].data, vt[i].l, vt[i].val, vt[i].c);
            step();
            chk($sformatf("v%0d_count", i), int'(if0.count), vt[i].e_cnt);
            chk($sformatf("v%0d_empty", i), int'(if0.empty), int'(vt[i].e_cnt == 0));
            chk($sformatf("v%0d_full", i),  int'(if0.full),  int'(vt[i].e_cnt == DP));
            chk($sformatf("v%0d_top", i),   int'(if0.pop_data), vt[i].e_top);
            chk($sformatf("v%0d_ovf", i),   int'(if0.overflow), int'(vt[i].e_ovf));
            chk($sformatf("v%0d_unf", i),   int'(if0.underflow), int'(vt[i].e_unf));
        end

        // ---- circular overwrite: push 1..6 into DEPTH=4 ----
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            drive(1, 0, v, 0, 0, 0);
            step();
        end
        chk("circ_count", int'(if1.count), 4);
        chk("circ_ovf",   int'(if1.overflow), 1);
        chk("circ_full",  int'(if1.full), 1);
        chk("rej_top",    int'(if0.pop_data), 4);
        exp_q = {13'd6, 13'd5, 13'd4, 13'd3};
        while (exp_q.size() > 0) begin
            chk("circ_pop", int'(if1.pop_data), int'(exp_q.pop_front()));
            drive(0, 1, 0, 0, 0, 0);
            step();
        end
        chk("circ_empty", int'(if1.empty), 1);

        // ---- replace top while full: no flag ----
        drive(0, 0, 0, 0, 0, 1);
        step();
        for (int v = 7; v <= 10; v++) begin
            drive(1, 0, v, 0, 0, 0);
            step();
        end
        drive(1, 1, 'h1F, 0, 0, 0);
        step();
        chk("repl_full_count", int'(if0.count), 4);
        chk("repl_full_top",   int'(if0.pop_data), 'h1F);
        chk("repl_full_ovf",   int'(if0.overflow), 0);
        chk("repl_full_ovf_c", int'(if1.overflow), 0);

        // ---- reset in the middle of a push ----
        drive(1, 0, 'h33, 0, 0, 0);
        step();
        reset = 1'b1;
        drive(1, 0, 'h44, 0, 0, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("rstmid_count", int'(if0.count), 0);
        chk("rstmid_empty", int'(if0.empty), 1);
        chk("rstmid_ovf",   int'(if0.overflow), 0);
        chk("rstmid_unf",   int'(if0.underflow), 0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r == 0);
            drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  int'($urandom_range(0, (1 << DW) - 1)),
                  logic'(r >= 1 && r <= 4), int'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 9) == 0));
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
